switch_debounce: RTL and testbench

Conditions the raw 16-bit slide-switch inputs from the board pins before the switch bus peripheral sees them. Each bit passes through a two-flop synchronizer and a tick-sampled stability filter, so the peripheral's switch input and its change interrupt are driven only by clean, glitch-free levels. The block also emits a one-cycle `changed_o` pulse whenever any debounced bit flips.

---
 rtl/switch_pkg.sv | 13 +
 rtl/debounce_bit.sv | 49 ++++
 rtl/switch_debounce.sv | 57 +++++
 tb/tb_switch_debounce.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared defaults and helpers for the switch debouncer
package switch_pkg;

    localparam int SW_WIDTH    = 16;
    localparam int SW_TICK_DIV = 100000;
    localparam int SW_SAMPLES  = 4;

    // Prescaler width; a divide-by-one still needs a one-bit counter.
    function automatic int tick_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchronizer, tick-sampled history and stable flop for one switch bit
module debounce_bit
    import switch_pkg::*;
#(
    parameter int SAMPLES = SW_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic flip
);

    logic               sync1;
    logic               sync2;
    logic [SAMPLES-2:0] hist;
    logic [SAMPLES-1:0] cand;
    logic               next_stable;

    assign cand = {hist, sync2};

    // A new level is accepted only when every sample in the window agrees.
    always_comb begin
        next_stable = stable;
        if (tick && ((&cand) || !(|cand))) begin
            next_stable = sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            hist   <= '0;
            stable <= 1'b0;
            flip   <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            if (tick) begin
                hist <= cand[SAMPLES-2:0];
            end
            stable <= next_stable;
            flip   <= next_stable ^ stable;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - debounces a bank of slide switches and flags any accepted change
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH    = SW_WIDTH,
    parameter int TICK_DIV = SW_TICK_DIV,
    parameter int SAMPLES  = SW_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_o,
    output logic             changed_o
);

    localparam int              CNT_W     = tick_cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [WIDTH-1:0] flip;

    // With TICK_DIV = 1 the counter sits at zero and tick stays high.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SAMPLES(SAMPLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (sw_raw[i]),
            .stable(sw_o[i]),
            .flip  (flip[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            changed_o <= 1'b0;
        end else begin
            changed_o <= |flip;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce
module tb_switch_debounce;

    localparam int W = 16;
    localparam int T = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_o;
    logic         changed_o;
    logic [W-1:0] raw1;
    logic [W-1:0] sw1;
    logic         changed1;

    always #5 clk = ~clk;

    switch_debounce #(.WIDTH(W), .TICK_DIV(T), .SAMPLES(S)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_o(sw_o), .changed_o(changed_o)
    );

    switch_debounce #(.WIDTH(W), .TICK_DIV(1), .SAMPLES(2)) dut1 (
        .clk(clk), .rst(rst), .sw_raw(raw1), .sw_o(sw1), .changed_o(changed1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int ecnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [W-1:0] sw;
        logic         chg;
    } exp_t;

    exp_t         sb[$];
    exp_t         ent;
    exp_t         got;
    logic [W-1:0] m_s1, m_s2, m_sw, s2v, nsw;
    logic         m_flip, m_chg, allq;
    int           m_n;
    logic [W-1:0] m_samp[$];

    // Reference: raw is seen two edges late; every T-th edge takes a sample,
    // and a bit adopts a value once the last S samples all show it.
    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0;
            m_flip = 1'b0; m_chg = 1'b0; m_n = 0;
            m_samp.delete();
            for (int i = 0; i < S - 1; i++) m_samp.push_back('0);
        end else begin
            s2v  = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_raw;
            nsw  = m_sw;
            if (m_n % T == T - 1) begin
                m_samp.push_back(s2v);
                if (m_samp.size() > S) void'(m_samp.pop_front());
                for (int b = 0; b < W; b++) begin
                    allq = 1'b1;
                    foreach (m_samp[i]) if (m_samp[i][b] != s2v[b]) allq = 1'b0;
                    if (allq) nsw[b] = s2v[b];
                end
            end
            m_n++;
            m_chg  = m_flip;
            m_flip = (nsw != m_sw);
            m_sw   = nsw;
        end
        ent.sw  = m_sw;
        ent.chg = m_chg;
        sb.push_back(ent);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            got = sb.pop_front();
            if (!rst) got = '0;
            chk("sb_sw", sw_o, got.sw);
            chk("sb_changed", changed_o, got.chg);
        end
    end

    always @(negedge clk) if (changed_o === 1'b1) n_pulse++;
    always @(posedge clk) if (!rst) ecnt <= 0; else ecnt <= ecnt + 1;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_sw(input logic [W-1:0] mask, input logic [W-1:0] val, input int maxe,
                           output int k, output logic chg_at);
        k = 0;
        chg_at = 1'b0;
        while (k < maxe) begin
            @(posedge clk);
            #1;
            k++;
            if ((sw_o & mask) == val) begin
                chg_at = changed_o;
                #1;
                return;
            end
            #1;
        end
        k = -1;
    endtask

    task automatic wait_sw1(input logic [W-1:0] mask, input logic [W-1:0] val, input int maxe,
                            output int k, output logic chg_at);
        k = 0;
        chg_at = 1'b0;
        while (k < maxe) begin
            @(posedge clk);
            #1;
            k++;
            if ((sw1 & mask) == val) begin
                chg_at = changed1;
                #1;
                return;
            end
            #1;
        end
        k = -1;
    endtask

    task automatic chk_pulse(input string name);
        @(posedge clk);
        #1;
        chk({name, "_hi"}, changed_o, 1);
        @(posedge clk);
        #1;
        chk({name, "_lo"}, changed_o, 0);
        #1;
    endtask

    function automatic int exp_latency(input int c);
        int j = 3;
        while ((c + j - 1) % T != T - 1) j++;
        return j + (S - 1) * T;
    endfunction

    int           k;
    logic         c;
    logic [W-1:0] m;
    logic         seen;

    initial begin
        rst = 1'b0;
        sw_raw = '1;
        raw1 = '0;
        cyc(3);
        chk("reset_sw", sw_o, 0);
        chk("reset_changed", changed_o, 0);
        n_pulse = 0;
        rst = 1'b1;
        wait_sw('1, '1, 20, k, c);
        chk("reset_acquire_within14", (k >= 1 && k <= 14), 1);
        cyc(4);
        chk("reset_acquire_pulses", n_pulse, 1);

        sw_raw = '0;
        wait_sw('1, '0, 30, k, c);
        cyc(3);
        for (int ph = 0; ph < T; ph++) begin
            sw_raw = '0;
            wait_sw(16'h1, 16'h0, 30, k, c);
            cyc(3);
            for (int g = 0; g < T && (ecnt % T) != ph; g++) cyc(1);
            sw_raw = 16'h0001;
            wait_sw(16'h1, 16'h1, 30, k, c);
            chk($sformatf("latency_ph%0d", ph), k, exp_latency(ph));
            chk($sformatf("latency_range_ph%0d", ph), (k >= 11 && k <= 14), 1);
            chk($sformatf("latency_chg_early_ph%0d", ph), c, 0);
            chk_pulse($sformatf("latency_pulse_ph%0d", ph));
        end

        sw_raw = '0;
        cyc(20);
        n_pulse = 0;
        sw_raw[3] = 1'b1;
        cyc(7);
        sw_raw[3] = 1'b0;
        cyc(25);
        chk("glitch7_sw", sw_o, 0);
        chk("glitch7_pulses", n_pulse, 0);
        sw_raw[3] = 1'b1;
        cyc(20);
        sw_raw[3] = 1'b0;
        chk("pulse20_sw3", sw_o[3], 1);
        wait_sw('1, '0, 30, k, c);
        cyc(3);

        n_pulse = 0;
        sw_raw = 16'h8001;
        wait_sw(16'h8001, 16'h8001, 30, k, c);
        chk("simul_both_bits", sw_o, 16'h8001);
        cyc(4);
        chk("simul_one_pulse", n_pulse, 1);

        sw_raw = '0;
        wait_sw('1, '0, 30, k, c);
        cyc(4);
        n_pulse = 0;
        for (int i = 0; i < 14; i++) begin
            sw_raw[5] = ~sw_raw[5];
            cyc(3);
        end
        sw_raw[5] = 1'b0;
        cyc(20);
        chk("chatter_sw5", sw_o[5], 0);
        chk("chatter_pulses", n_pulse, 0);

        sw_raw = 16'h00F0;
        wait_sw('1, 16'h00F0, 30, k, c);
        @(posedge clk);
        #3;
        chk("async_pre_changed", changed_o, 1);
        rst = 1'b0;
        #1;
        chk("async_sw", sw_o, 0);
        chk("async_changed", changed_o, 0);
        cyc(3);
        n_pulse = 0;
        rst = 1'b1;
        wait_sw('1, 16'h00F0, 20, k, c);
        chk("async_reacquire_range", (k >= 11 && k <= 14), 1);
        cyc(4);
        chk("async_reacquire_pulses", n_pulse, 1);

        for (int i = 0; i < 60; i++) begin
            m = '0;
            repeat ($urandom_range(1, 3)) m[$urandom_range(0, W - 1)] = 1'b1;
            sw_raw = sw_raw ^ m;
            cyc($urandom_range(1, 18));
        end
        cyc(30);

        raw1[0] = 1'b1;
        wait_sw1(16'h1, 16'h1, 10, k, c);
        chk("div1_latency", k, 4);
        @(posedge clk);
        #1;
        chk("div1_pulse", changed1, 1);
        #1;
        cyc(6);
        seen = 1'b0;
        raw1[1] = 1'b1;
        cyc(1);
        raw1[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seen = seen | sw1[1] | changed1;
            #1;
        end
        chk("div1_glitch_rejected", seen, 0);
        chk("div1_final_sw", sw1, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
